uart_tx_arbiter: RTL and testbench

- Shares the UART transmit path between two word-wide requesters (A, B).
- Grants one requester at a time, round-robin, and serializes its NB_WORD-bit word LSB-byte-first into the UART TX FIFO.
- Independently schedules the UART transmitter: pulses tx_start whenever the UART is idle and the TX FIFO holds data.
- Sits between on-chip producers and the write/tx_start/status ports of the UART top.

---
 rtl/uart_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin two-requester word serializer and UART tx scheduler (optional header: UART_ARB_HEADER_EN)
module uart_tx_arbiter #(
    parameter int NB_DATA = 8,
    parameter int NB_WORD = 32,
    parameter int NB_CNT  = 3
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_a_valid,
    input  logic [NB_WORD-1:0] i_a_data,
    output logic               o_a_ready,
    input  logic               i_b_valid,
    input  logic [NB_WORD-1:0] i_b_data,
    output logic               o_b_ready,
    output logic               o_wr,
    output logic [NB_DATA-1:0] o_wdata,
    input  logic               i_tx_full,
    input  logic               i_tx_empty,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_busy,
    output logic [1:0]         o_grant
);

    localparam logic [NB_CNT-1:0] WORD_BYTES = NB_CNT'(NB_WORD / NB_DATA);
    localparam logic [NB_CNT-1:0] CNT_ONE    = NB_CNT'(1);
`ifdef UART_ARB_HEADER_EN
    localparam logic [NB_DATA-1:0] HDR_A = NB_DATA'(8'hA0);
    localparam logic [NB_DATA-1:0] HDR_B = NB_DATA'(8'hB0);
`endif

`ifdef UART_ARB_HEADER_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_HDR = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1} state_t;
`endif

    state_t             r_state;
    logic [NB_WORD-1:0] r_shift;
    logic [NB_CNT-1:0]  r_cnt;
    logic               r_last_b;
    logic [1:0]         r_grant;
    logic               r_tx_start;
    logic               r_tx_busy;

    logic               w_pick_a;
    logic               w_pick_b;
    logic               w_wr;

    // Round-robin pick: a lone requester wins, a tie goes to whoever did not own the last word
    always_comb begin
        w_pick_a = 1'b0;
        w_pick_b = 1'b0;
        if (r_state == S_IDLE && i_en) begin
            if (i_a_valid && (!i_b_valid || r_last_b)) begin
                w_pick_a = 1'b1;
            end else if (i_b_valid) begin
                w_pick_b = 1'b1;
            end
        end
    end

    assign w_wr      = (r_state != S_IDLE) && !i_tx_full;
    assign o_wr      = w_wr;
    assign o_a_ready = w_pick_a;
    assign o_b_ready = w_pick_b;
    assign o_grant   = r_grant;
    assign o_tx_start = r_tx_start;
    assign o_busy    = (r_state != S_IDLE) || r_tx_busy;

    // FIFO write data: header byte in HDR, otherwise the low byte of the shift register
    always_comb begin
        o_wdata = '0;
        if (r_state == S_SEND) begin
            o_wdata = r_shift[NB_DATA-1:0];
        end
`ifdef UART_ARB_HEADER_EN
        if (r_state == S_HDR) begin
            o_wdata = r_grant[1] ? HDR_B : HDR_A;
        end
`endif
    end

    // Word FSM: capture on grant, then emit one byte per non-full cycle until the counter runs out
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_last_b <= 1'b1;
            r_grant  <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_a || w_pick_b) begin
                        r_shift <= w_pick_a ? i_a_data : i_b_data;
                        r_cnt   <= WORD_BYTES;
                        r_grant <= {w_pick_b, w_pick_a};
`ifdef UART_ARB_HEADER_EN
                        r_state <= S_HDR;
`else
                        r_state <= S_SEND;
`endif
                    end
                end
`ifdef UART_ARB_HEADER_EN
                S_HDR: begin
                    if (w_wr) begin
                        r_state <= S_SEND;
                    end
                end
`endif
                S_SEND: begin
                    if (w_wr) begin
                        r_shift <= r_shift >> NB_DATA;
                        r_cnt   <= r_cnt - CNT_ONE;
                        if (r_cnt == CNT_ONE) begin
                            r_last_b <= r_grant[1];
                            r_grant  <= 2'b00;
                            r_state  <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Tx scheduler: one start per idle period while the FIFO holds data; done always wins over a new start
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_start <= 1'b0;
            r_tx_busy  <= 1'b0;
        end else if (i_tx_done) begin
            r_tx_start <= 1'b0;
            r_tx_busy  <= 1'b0;
        end else if (i_en && !r_tx_busy && !i_tx_empty && !r_tx_start) begin
            r_tx_start <= 1'b1;
            r_tx_busy  <= 1'b1;
        end else begin
            r_tx_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int NB_DATA = 8;
    localparam int NB_WORD = 32;
    localparam int NB_CNT  = 3;
    localparam int NBYTES  = NB_WORD / NB_DATA;
`ifdef UART_ARB_HEADER_EN
    localparam int NWB = NBYTES + 1;
`else
    localparam int NWB = NBYTES;
`endif

    logic               clk = 1'b0;
    logic               i_rst_n;
    logic               i_en;
    logic               i_a_valid;
    logic [NB_WORD-1:0] i_a_data;
    logic               o_a_ready;
    logic               i_b_valid;
    logic [NB_WORD-1:0] i_b_data;
    logic               o_b_ready;
    logic               o_wr;
    logic [NB_DATA-1:0] o_wdata;
    logic               i_tx_full;
    logic               i_tx_empty;
    logic               o_tx_start;
    logic               i_tx_done;
    logic               o_busy;
    logic [1:0]         o_grant;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NB_DATA(NB_DATA), .NB_WORD(NB_WORD), .NB_CNT(NB_CNT)) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_en(i_en),
        .i_a_valid(i_a_valid), .i_a_data(i_a_data), .o_a_ready(o_a_ready),
        .i_b_valid(i_b_valid), .i_b_data(i_b_data), .o_b_ready(o_b_ready),
        .o_wr(o_wr), .o_wdata(o_wdata), .i_tx_full(i_tx_full), .i_tx_empty(i_tx_empty),
        .o_tx_start(o_tx_start), .i_tx_done(i_tx_done), .o_busy(o_busy), .o_grant(o_grant)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected FIFO byte stream plus a UART that answers each start with a done
    logic [7:0] exp_q[$];
    int         owner_log[$];
    int         cur_owner, last_owner, ready_seen;
    int         wr_seen, a_ready_cnt, starts_seen;
    bit         uart_busy, p_en, p_empty, p_busy, p_start, p_done;
    bit         uart_auto;
    int         done_cnt, dmin, dmax;

    task automatic model_reset();
        exp_q.delete();
        owner_log.delete();
        cur_owner = 0; last_owner = 2; ready_seen = 0;
        uart_busy = 0; p_en = 0; p_empty = 0; p_busy = 0; p_start = 0; p_done = 0;
        done_cnt = 0;
    endtask

    task automatic push_word(input int owner, input logic [31:0] w);
`ifdef UART_ARB_HEADER_EN
        exp_q.push_back(owner == 1 ? 8'hA0 : 8'hB0);
`endif
        for (int i = 0; i < NBYTES; i++) exp_q.push_back(w[i*8 +: 8]);
    endtask

    task automatic tick();
        int         pick;
        bit         exp_wr, exp_start, active;
        logic [1:0] exp_rdy, exp_grant;
        @(negedge clk);
        active = (exp_q.size() != 0);
        pick = 0;
        if (i_en && !active) begin
            if (i_a_valid && i_b_valid) pick = (last_owner == 1) ? 2 : 1;
            else if (i_a_valid)         pick = 1;
            else if (i_b_valid)         pick = 2;
        end
        exp_rdy = (pick == 1) ? 2'b01 : (pick == 2) ? 2'b10 : 2'b00;
        check("ready", {o_b_ready, o_a_ready}, exp_rdy);
        exp_grant = !active ? 2'b00 : (cur_owner == 1) ? 2'b01 : 2'b10;
        check("grant", o_grant, exp_grant);
        exp_wr = active && !i_tx_full;
        check("wr", o_wr, exp_wr);
        if (exp_wr && o_wr) begin
            check("wdata", o_wdata, exp_q[0]);
            void'(exp_q.pop_front());
            wr_seen++;
            if (exp_q.size() == 0) last_owner = cur_owner;
        end
        if (o_a_ready) a_ready_cnt++;
        if (pick != 0) begin
            ready_seen = pick;
            cur_owner  = pick;
            owner_log.push_back(pick);
            push_word(pick, pick == 1 ? i_a_data : i_b_data);
        end
        exp_start = p_en && !p_empty && !p_busy && !p_start && !p_done;
        check("tx_start", o_tx_start, exp_start);
        if (o_tx_start) begin
            uart_busy = 1;
            starts_seen++;
            if (uart_auto) done_cnt = $urandom_range(dmax, dmin);
        end
        check("busy", o_busy, active || uart_busy);
        p_en = i_en; p_empty = i_tx_empty; p_busy = uart_busy; p_start = o_tx_start; p_done = i_tx_done;
        if (i_tx_done) uart_busy = 0;
        @(posedge clk);
        #1;
        i_tx_done = 1'b0;
        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) i_tx_done = 1'b1;
        end
    endtask

    task automatic drain(input int bound, output int n);
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        check("drain_done", exp_q.size() == 0, 1);
    endtask

    task automatic zero_inputs();
        i_en = 0; i_a_valid = 0; i_b_valid = 0; i_a_data = '0; i_b_data = '0;
        i_tx_full = 0; i_tx_empty = 0; i_tx_done = 0;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        zero_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {o_a_ready, o_b_ready, o_wr, o_wdata, o_tx_start, o_busy, o_grant}, 0);
        model_reset();
        i_rst_n = 1'b1;
    endtask

    typedef struct {
        bit          av;
        bit          bv;
        logic [31:0] ad;
        logic [31:0] bd;
        int          owner;
    } vec_t;
    vec_t tbl[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n, w0, stall_wr;
        tbl[0] = '{1'b1, 1'b0, 32'h44332211, 32'h0,        1};
        tbl[1] = '{1'b0, 1'b1, 32'h0,        32'h04030201, 2};
        tbl[2] = '{1'b1, 1'b1, 32'hA1A2A3A4, 32'hB1B2B3B4, 1};
        tbl[3] = '{1'b1, 1'b1, 32'hA1A2A3A4, 32'hB1B2B3B4, 2};
        tbl[4] = '{1'b1, 1'b1, 32'hA1A2A3A4, 32'hB1B2B3B4, 1};
        tbl[5] = '{1'b0, 1'b1, 32'h0,        32'hCAFEF00D, 2};
        tbl[6] = '{1'b0, 1'b1, 32'h0,        32'h12345678, 2};
        tbl[7] = '{1'b1, 1'b1, 32'h87654321, 32'h0BADBEEF, 1};
        uart_auto = 0; dmin = 16; dmax = 16;
        wr_seen = 0; a_ready_cnt = 0; starts_seen = 0;

        // Reset, then 20 quiet cycles with every input low
        do_reset();
        for (int c = 0; c < 20; c++) begin
            check("quiet_outputs", {o_a_ready, o_b_ready, o_wr, o_wdata, o_tx_start, o_busy, o_grant}, 0);
            tick();
        end

        // Single A word, FIFO never full: one ready, bytes on back-to-back cycles
        i_en = 1; i_tx_empty = 1;
        i_a_valid = 1; i_a_data = 32'h44332211;
        a_ready_cnt = 0; w0 = wr_seen;
        tick();
        i_a_valid = 0; i_a_data = $urandom;
        drain(40, n);
        check("a_word_cycles", n, NWB);
        tick();
        check("a_ready_once", a_ready_cnt, 1);
        check("a_word_bytes", wr_seen - w0, NWB);

        // Table: one word per entry, owner predicted by hand (last owner is A at this point)
        for (int k = 1; k < 8; k++) begin
            i_a_valid = tbl[k].av; i_a_data = tbl[k].ad;
            i_b_valid = tbl[k].bv; i_b_data = tbl[k].bd;
            ready_seen = 0;
            for (int c = 0; c < 20 && ready_seen == 0; c++) tick();
            check("tbl_owner", ready_seen, tbl[k].owner);
            i_a_valid = 0; i_b_valid = 0; i_a_data = $urandom; i_b_data = $urandom;
            drain(60, n);
        end

        // Both requesters valid continuously from reset: A, B, A, B
        do_reset();
        i_en = 1; i_tx_empty = 1;
        i_a_valid = 1; i_a_data = 32'hA1A2A3A4;
        i_b_valid = 1; i_b_data = 32'hB1B2B3B4;
        for (int c = 0; c < 200 && owner_log.size() < 4; c++) tick();
        i_a_valid = 0; i_b_valid = 0;
        drain(60, n);
        check("rr_count", owner_log.size(), 4);
        for (int k = 0; k < 4 && k < owner_log.size(); k++) check("rr_order", owner_log[k], (k % 2 == 0) ? 1 : 2);

        // FIFO full after the 2nd byte for 10 cycles: no writes, then the rest with no loss
        i_a_valid = 1; i_a_data = 32'h44332211;
        w0 = wr_seen;
        tick();
        i_a_valid = 0;
        for (int c = 0; c < 20 && wr_seen - w0 < 2; c++) tick();
        check("stall_pre_bytes", wr_seen - w0, 2);
        i_tx_full = 1;
        stall_wr = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (o_wr) stall_wr++;
            @(posedge clk);
            #1;
            tick();
        end
        check("stall_no_wr", stall_wr, 0);
        i_tx_full = 0;
        drain(40, n);
        check("stall_total_bytes", wr_seen - w0, NWB);

        // Scheduler: done 16 cycles after each start, then i_en low blocks new starts
        i_tx_empty = 0; uart_auto = 1; dmin = 16; dmax = 16; starts_seen = 0;
        for (int c = 0; c < 100; c++) tick();
        check("sched_starts", starts_seen >= 5, 1);
        i_en = 0;
        tick();
        starts_seen = 0;
        for (int c = 0; c < 60; c++) tick();
        check("sched_en_off", starts_seen, 0);
        i_en = 1;

        // Randomized traffic against the model
        dmin = 1; dmax = 8;
        for (int c = 0; c < 2500; c++) begin
            i_a_valid = ($urandom_range(1, 0) == 1);
            i_b_valid = ($urandom_range(1, 0) == 1);
            i_a_data  = $urandom;
            i_b_data  = $urandom;
            i_tx_full = ($urandom_range(3, 0) == 0);
            i_en      = ($urandom_range(9, 0) != 0);
            tick();
        end
        i_a_valid = 0; i_b_valid = 0; i_tx_full = 0; i_en = 1;
        drain(60, n);
        i_tx_empty = 1;
        for (int c = 0; c < 30 && uart_busy; c++) tick();
        check("uart_settled", uart_busy, 0);
        uart_auto = 0;

        // Reset in the middle of a word: outputs clear at once, next tie goes to A
        i_a_valid = 1; i_a_data = 32'hDEADBEEF;
        tick();
        i_a_valid = 0;
        tick();
        tick();
        #2;
        i_rst_n = 0;
        #1;
        check("midword_reset", {o_a_ready, o_b_ready, o_wr, o_wdata, o_tx_start, o_busy, o_grant}, 0);
        do_reset();
        i_en = 1; i_tx_empty = 1;
        i_a_valid = 1; i_b_valid = 1; i_a_data = 32'h01020304; i_b_data = 32'h05060708;
        ready_seen = 0;
        for (int c = 0; c < 5 && ready_seen == 0; c++) tick();
        check("post_reset_owner", ready_seen, 1);
        i_a_valid = 0; i_b_valid = 0;
        drain(40, n);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
